// File: rtl/ram_clear.sv
// ram_clear: parametrised word-addressed RAM with a hardware clear engine.
//
// A user write (load) stores `in` at `address` on the rising edge. A clear
// request starts a sweep that writes FILL to every word, one word per cycle,
// from address 0 up to DEPTH-1. While sweeping, user writes and further clear
// requests are ignored. `done` pulses for one cycle after the final write.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous, active-high; aborts a sweep, leaves memory intact
//   address  - word address for combinational read and for user write
//   in       - write data
//   load     - write enable (honoured only while idle)
//   clear    - sweep start request (honoured only while idle)
//   out      - combinational read data, mem[address]
//   busy     - high while a sweep is in progress
//   done     - one-cycle pulse after a sweep completes
module ram_clear #(
  parameter int               WIDTH     = 16,
  parameter int               ADDR_BITS = 9,
  parameter logic [WIDTH-1:0] FILL      = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [WIDTH-1:0]     in,
  input  logic                 load,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 busy,
  output logic                 done
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t               state_reg, state_next;
  logic [ADDR_BITS-1:0] ptr_reg, ptr_next;
  logic                 done_reg, done_next;

  // Single write port shared by user writes and the sweep.
  logic                 we;
  logic [ADDR_BITS-1:0] waddr;
  logic [WIDTH-1:0]     wdata;

  logic [WIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    done_next  = 1'b0;
    we         = 1'b0;
    waddr      = address;
    wdata      = in;
    case (state_reg)
      IDLE: begin
        // A simultaneous load and clear performs the write; the sweep
        // overwrites that word later.
        we = load;
        if (clear) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        we       = 1'b1;
        waddr    = ptr_reg;
        wdata    = FILL;
        ptr_next = ptr_reg + ADDR_BITS'(1);   // wraps to 0 after LAST_ADDR
        if (ptr_reg == LAST_ADDR) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      done_reg  <= done_next;
    end
  end

  // Memory has no reset; a reset edge suppresses any write so that an
  // aborted sweep leaves untouched words with their old contents.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[waddr] <= wdata;
    end
  end

  assign out  = mem[address];
  assign busy = (state_reg == SWEEP);
  assign done = done_reg;

endmodule

// File: doc/ram_clear.md
# ram_clear

Parametrised word-addressed RAM, the successor to the fixed 512×16 RAM in the memory tier. It keeps the same load/address/in/out port style and adds:
- configurable width and depth;
- a hardware clear engine that sweeps every word to a fill value, with `busy` and `done` status.

It sits between the CPU data path and the memory map and is used wherever a RAM must be zeroed without CPU write loops.

## Interface
- `WIDTH`, 16: data word width in bits.
- `ADDR_BITS`, 9: address width; depth is `DEPTH = 2**ADDR_BITS` (derived, not overridable).
- `FILL`, 0: value written to every word by a clear sweep; `WIDTH` bits.
- `clk`  input  1: single clock; all state changes on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `address`  input  ADDR_BITS: word address for read and for user write.
- `in`  input  WIDTH: write data.
- `load`  input  1: write enable; `in` is written to `mem[address]` at the rising edge.
- `clear`  input  1: start request for a clear sweep; sampled at the rising edge.
- `out`  output  WIDTH: combinational read, `mem[address]`.
- `busy`  output  1: a sweep is in progress.
- `done`  output  1: one-cycle pulse when a sweep completes.

## Operation
- State machine with 2 states: IDLE and SWEEP. There is a sweep pointer `ptr` of `ADDR_BITS` bits.
- **reset = 1 at an edge:**
  - state becomes IDLE, `ptr` becomes 0, `busy` becomes 0, `done` becomes 0;
  - memory contents are untouched, and `load` is ignored at that edge;
  - reset has priority over `clear` and `load`.
- **IDLE:**
  - if `load` = 1, write `mem[address] = in`;
  - if `clear` = 1, go to SWEEP with `ptr` = 0;
  - if `load` and `clear` are both 1 at the same edge, the write is performed and the sweep starts; the sweep later overwrites that word with `FILL`.
- **SWEEP:**
  - each edge writes `mem[ptr] = FILL` and increments `ptr`;
  - `load` is ignored (the write is dropped and there is no error flag);
  - `clear` is ignored, so a sweep is never restarted;
  - on the edge that writes `ptr = DEPTH-1`, go to IDLE, set `ptr` to 0 (natural wrap) and set `done` to 1.
- **`done`:** it is 1 only for the cycle after the final sweep write, and returns to 0 at the next edge.
- **Reset mid-sweep:** the sweep is aborted and the machine returns to IDLE.
  - Words already swept hold `FILL`; the remaining words keep their old contents.
  - `done` does not pulse.
- **`out`:** always `mem[address]`, combinational, in both states.
  - During SWEEP it reflects words as they are cleared.
  - The word at `address` shows its new value immediately after the write edge.
- **Power-up:** memory is uninitialised (X in simulation) until written or swept.

## Timing
- Write latency is 1 edge: with `load` high before edge N, `out` shows `in` after edge N when the address is unchanged.
- Read latency is 0 cycles: `out` is combinational from `address` and memory.
- **Sweep, with `clear` sampled at edge N:**
  - `busy` goes to 1 after edge N;
  - edges N+1 to N+DEPTH write addresses 0 to DEPTH-1;
  - after edge N+DEPTH, `busy` goes to 0 and `done` goes to 1;
  - after edge N+DEPTH+1, `done` goes to 0;
  - total sweep length is DEPTH cycles.
- A `load` or `clear` presented in the `done` cycle is accepted, because the state is already IDLE.
- Reset values: `busy` = 0, `done` = 0; `out` follows memory and has no reset value.

## Test plan
- **Default params, write/readback:** write `0x1234`@0, `0xBEEF`@3, `0x00FF`@7, `0xA5A5`@511, each with `load` = 1. Then set `load` = 0 and read each address: `out` equals the written value. `in` = `0xFFFF` with `load` = 0 at @511 leaves it at `0xA5A5`.
- **ADDR_BITS=3, FILL=`0x00AA`, full sweep:** preload all 8 words with `0x1111`, pulse `clear` for 1 cycle.
  - `busy` is high for exactly 8 cycles, and `done` is high for 1 cycle immediately after.
  - Every address then reads `0x00AA`.
- **Load during sweep:** start the sweep, then in the 3rd busy cycle apply `load` with `0x7777`@5. After `done`, @5 reads `0x00AA`.
- **Simultaneous load and clear in IDLE:** `load` `0x5555`@2 together with `clear`. `out`@2 reads `0x5555` right after that edge, then `0x00AA` after the sweep completes.
- **Reset mid-sweep:** preload `0x1111` and assert `reset` at the edge that would write `ptr` = 4.
  - Addresses 0–3 read `0x00AA`; addresses 4–7 read `0x1111`.
  - `busy` = 0 and `done` never pulses.
- **Clear while busy and back-to-back:** assert `clear` every cycle for 20 cycles (ADDR_BITS=3).
  - `busy` shows 8 high cycles, then a 1-cycle `done` pulse with `busy` low, then a new 8-cycle sweep.
  - There is no restart in the middle of a sweep.
